// File: rtl/kinase_valve_sequencer.sv
// Valve and pump sequencer for the kinase activity chip control pads.
// Accepts one command at a time, holds the valve/select pattern, waits a
// settle time, runs N peristaltic strokes on pump A or B, then pulses done.
// Pad level 1 = valve pressurized (closed).
module kinase_valve_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PHASE_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [12:0] cmd_valves,
  input  logic [3:0]  cmd_select,
  input  logic        cmd_pump,
  input  logic [7:0]  cmd_strokes,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [12:0] pad_ctrl_a,
  output logic [3:0]  pad_ctrl_s,
  output logic [2:0]  pad_pump_a,
  output logic [1:0]  pad_pump_b
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PHASE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, PUMP} state_t;

  state_t        state;
  logic          pump_sel;
  logic [7:0]    strokes;
  logic [7:0]    stroke_cnt;
  logic [2:0]    phase_idx;
  logic [PW-1:0] phase_cnt;
  logic [SW-1:0] settle_cnt;

  // Pump A 3-valve peristaltic sequence (one stroke = 6 phases).
  function automatic logic [2:0] pat_a(input logic [2:0] idx);
    case (idx)
      3'd0:    pat_a = 3'b101;
      3'd1:    pat_a = 3'b100;
      3'd2:    pat_a = 3'b110;
      3'd3:    pat_a = 3'b010;
      3'd4:    pat_a = 3'b011;
      default: pat_a = 3'b001;
    endcase
  endfunction

  // Pump B 2-valve alternating sequence (one stroke = 2 phases).
  function automatic logic [1:0] pat_b(input logic [2:0] idx);
    pat_b = (idx == 3'd0) ? 2'b10 : 2'b01;
  endfunction

  // Ready is combinational so a command can be taken in the done cycle.
  assign cmd_ready = (state == IDLE) && !rst;

  // Sequencer FSM with registered pad drives; rst > abort > acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pad_ctrl_a <= 13'h1FFF;
      pad_ctrl_s <= 4'h0;
      pad_pump_a <= 3'b111;
      pad_pump_b <= 2'b11;
      pump_sel   <= 1'b0;
      strokes    <= 8'd0;
      stroke_cnt <= 8'd0;
      phase_idx  <= 3'd0;
      phase_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        busy       <= 1'b0;
        pad_ctrl_a <= 13'h1FFF;
        pad_ctrl_s <= 4'h0;
        pad_pump_a <= 3'b111;
        pad_pump_b <= 2'b11;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              state      <= SETTLE;
              busy       <= 1'b1;
              pad_ctrl_a <= cmd_valves;
              pad_ctrl_s <= cmd_select;
              pump_sel   <= cmd_pump;
              strokes    <= cmd_strokes;
              settle_cnt <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              if (strokes == 8'd0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                // Phase 0 must already be on the pads in the first PUMP cycle.
                state      <= PUMP;
                phase_cnt  <= '0;
                phase_idx  <= 3'd0;
                stroke_cnt <= 8'd0;
                pad_pump_a <= pump_sel ? 3'b111 : pat_a(3'd0);
                pad_pump_b <= pump_sel ? pat_b(3'd0) : 2'b11;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          PUMP: begin
            if (phase_cnt == PHASE_LAST) begin
              phase_cnt <= '0;
              if (phase_idx == (pump_sel ? 3'd1 : 3'd5)) begin
                // Stroke count compared against latched target: no wrap at 255.
                if (stroke_cnt + 8'd1 == strokes) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  pad_pump_a <= 3'b111;
                  pad_pump_b <= 2'b11;
                end else begin
                  stroke_cnt <= stroke_cnt + 8'd1;
                  phase_idx  <= 3'd0;
                  pad_pump_a <= pump_sel ? 3'b111 : pat_a(3'd0);
                  pad_pump_b <= pump_sel ? pat_b(3'd0) : 2'b11;
                end
              end else begin
                phase_idx  <= phase_idx + 3'd1;
                pad_pump_a <= pump_sel ? 3'b111 : pat_a(phase_idx + 3'd1);
                pad_pump_b <= pump_sel ? pat_b(phase_idx + 3'd1) : 2'b11;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Directed bench for kinase_valve_sequencer (S=4, P=2).
// Cycle c is sampled on the falling edge after the c-th rising edge
// following the acceptance edge.
module tb_kinase_valve_sequencer;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_pump, abort, busy, done;
  logic [12:0] cmd_valves, pad_ctrl_a;
  logic [3:0]  cmd_select, pad_ctrl_s;
  logic [7:0]  cmd_strokes;
  logic [2:0]  pad_pump_a;
  logic [1:0]  pad_pump_b;

  int checks = 0;
  int passed = 0;

  logic [2:0] pa_tab [6];
  logic [1:0] pb_tab [2];

  always #5 clk = ~clk;

  kinase_valve_sequencer #(.SETTLE_CYCLES(4), .PHASE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_valves(cmd_valves), .cmd_select(cmd_select), .cmd_pump(cmd_pump),
    .cmd_strokes(cmd_strokes), .abort(abort), .busy(busy), .done(done),
    .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s),
    .pad_pump_a(pad_pump_a), .pad_pump_b(pad_pump_b)
  );

  // Present a command and let it be taken on the next rising edge (edge 0).
  task automatic issue(input logic [12:0] v, input logic [3:0] s,
                       input logic p, input logic [7:0] n);
    cmd_valves = v; cmd_select = s; cmd_pump = p; cmd_strokes = n;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; abort = 1'b0;
    cmd_valves = 13'h0123; cmd_select = 4'hF; cmd_pump = 1'b0; cmd_strokes = 8'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready c%0d got %b want 0", c, cmd_ready); else passed++;
      checks++; if ({pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b} !== {13'h1FFF, 4'h0, 3'b111, 2'b11})
        $display("FAIL reset_pads c%0d got %h/%h/%b/%b want 1fff/0/111/11", c, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b);
      else passed++;
      checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done c%0d got %b want 00", c, {busy, done}); else passed++;
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", cmd_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_pump_a;
    logic [2:0] ea;
    issue(13'h0A5A, 4'b0100, 1'b0, 8'd2);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      ea = (c >= 5 && c <= 28) ? pa_tab[((c - 5) / 2) % 6] : 3'b111;
      checks++; if (pad_pump_a !== ea) $display("FAIL pumpA_a c%0d got %b want %b", c, pad_pump_a, ea); else passed++;
      checks++; if (pad_pump_b !== 2'b11) $display("FAIL pumpA_b c%0d got %b want 11", c, pad_pump_b); else passed++;
      checks++; if (done !== (c == 29)) $display("FAIL pumpA_done c%0d got %b want %b", c, done, c == 29); else passed++;
      checks++; if (busy !== (c <= 28)) $display("FAIL pumpA_busy c%0d got %b want %b", c, busy, c <= 28); else passed++;
      checks++; if (cmd_ready !== (c >= 29)) $display("FAIL pumpA_ready c%0d got %b want %b", c, cmd_ready, c >= 29); else passed++;
      checks++; if ({pad_ctrl_a, pad_ctrl_s} !== {13'h0A5A, 4'b0100})
        $display("FAIL pumpA_ctrl c%0d got %h/%h want 0a5a/4", c, pad_ctrl_a, pad_ctrl_s);
      else passed++;
    end
  endtask

  task automatic test_pump_b;
    logic [1:0] eb;
    issue(13'h1555, 4'b1001, 1'b1, 8'd3);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      eb = (c >= 5 && c <= 16) ? pb_tab[((c - 5) / 2) % 2] : 2'b11;
      checks++; if (pad_pump_b !== eb) $display("FAIL pumpB_b c%0d got %b want %b", c, pad_pump_b, eb); else passed++;
      checks++; if (pad_pump_a !== 3'b111) $display("FAIL pumpB_a c%0d got %b want 111", c, pad_pump_a); else passed++;
      checks++; if (done !== (c == 17)) $display("FAIL pumpB_done c%0d got %b want %b", c, done, c == 17); else passed++;
      checks++; if (busy !== (c <= 16)) $display("FAIL pumpB_busy c%0d got %b want %b", c, busy, c <= 16); else passed++;
    end
  endtask

  task automatic test_zero_strokes;
    issue(13'h0F0F, 4'b0011, 1'b0, 8'd0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if ({pad_pump_a, pad_pump_b} !== 5'b11111) $display("FAIL zero_pumps c%0d got %b/%b want 111/11", c, pad_pump_a, pad_pump_b); else passed++;
      checks++; if (done !== (c == 5)) $display("FAIL zero_done c%0d got %b want %b", c, done, c == 5); else passed++;
      checks++; if (busy !== (c <= 4)) $display("FAIL zero_busy c%0d got %b want %b", c, busy, c <= 4); else passed++;
      checks++; if (pad_ctrl_a !== 13'h0F0F) $display("FAIL zero_ctrl_a c%0d got %h want 0f0f", c, pad_ctrl_a); else passed++;
    end
    // Abort while idle clears the retained pattern.
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++; if ({pad_ctrl_a, pad_ctrl_s} !== {13'h1FFF, 4'h0}) $display("FAIL idle_abort_ctrl got %h/%h want 1fff/0", pad_ctrl_a, pad_ctrl_s); else passed++;
    checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL idle_abort_state got %b want 01", {busy, cmd_ready}); else passed++;
  endtask

  task automatic test_abort;
    issue(13'h0A5A, 4'b0100, 1'b0, 8'd2);
    repeat (10) @(negedge clk);
    checks++; if (pad_pump_a !== 3'b110) $display("FAIL abort_pre_a got %b want 110", pad_pump_a); else passed++;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++; if ({pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b} !== {13'h1FFF, 4'h0, 3'b111, 2'b11})
      $display("FAIL abort_pads got %h/%h/%b/%b want 1fff/0/111/11", pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b);
    else passed++;
    checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL abort_state got busy=%b ready=%b want 0/1", busy, cmd_ready); else passed++;
    for (int c = 11; c <= 35; c++) begin
      checks++; if (done !== 1'b0) $display("FAIL abort_no_done c%0d got %b want 0", c, done); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    // First command held valid through busy with a different pattern behind it.
    issue(13'h0F0F, 4'b0001, 1'b1, 8'd1);
    cmd_valid = 1'b1; cmd_valves = 13'h1234; cmd_select = 4'hA; cmd_pump = 1'b0; cmd_strokes = 8'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (pad_ctrl_a !== 13'h0F0F) $display("FAIL hold_ctrl_a c%0d got %h want 0f0f", c, pad_ctrl_a); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL hold_busy c%0d got %b want 1", c, busy); else passed++;
    end
    @(negedge clk);
    checks++; if ({done, cmd_ready} !== 2'b11) $display("FAIL b2b_done_cycle got done=%b ready=%b want 1/1", done, cmd_ready); else passed++;
    checks++; if (pad_ctrl_a !== 13'h0F0F) $display("FAIL b2b_old_ctrl got %h want 0f0f", pad_ctrl_a); else passed++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if ({pad_ctrl_a, pad_ctrl_s} !== {13'h1234, 4'hA}) $display("FAIL b2b_new_ctrl got %h/%h want 1234/a", pad_ctrl_a, pad_ctrl_s); else passed++;
    checks++; if ({busy, done, cmd_ready} !== 3'b100) $display("FAIL b2b_state got %b want 100", {busy, done, cmd_ready}); else passed++;
    // Second command is now in cycle 1; advance into PUMP, cycle 7 = phase 1.
    repeat (6) @(negedge clk);
    checks++; if (pad_pump_a !== 3'b100) $display("FAIL rst_pre_a got %b want 100", pad_pump_a); else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b} !== {13'h1FFF, 4'h0, 3'b111, 2'b11})
      $display("FAIL rst_pads got %h/%h/%b/%b want 1fff/0/111/11", pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b);
    else passed++;
    checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL rst_state got busy=%b ready=%b want 0/1", busy, cmd_ready); else passed++;
    for (int c = 0; c < 15; c++) begin
      checks++; if (done !== 1'b0) $display("FAIL rst_no_done +%0d got %b want 0", c, done); else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    pa_tab[0] = 3'b101; pa_tab[1] = 3'b100; pa_tab[2] = 3'b110;
    pa_tab[3] = 3'b010; pa_tab[4] = 3'b011; pa_tab[5] = 3'b001;
    pb_tab[0] = 2'b10;  pb_tab[1] = 2'b01;
    test_reset();
    test_pump_a();
    test_pump_b();
    test_zero_strokes();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/kinase_valve_sequencer.md
# kinase_valve_sequencer

Synchronous valve and pump sequencer that drives the control pads of the kinase activity chip (`pad_ctrl_a`, `pad_ctrl_s`, `pad_pump_a`, `pad_pump_b`). It is the off-chip/controller end of those pads:
- accepts one command at a time over a valid/ready handshake;
- latches the requested valve and select patterns;
- waits a settle time, then runs the requested number of peristaltic pump strokes;
- reports completion with a one-cycle pulse.

Pad logic level 1 = valve pressurized (closed).

## Interface
- `SETTLE_CYCLES`, default 4: cycles valves are held before pumping; must be ≥1.
- `PHASE_CYCLES`, default 2: cycles each pump phase is held; must be ≥1.

Ports (clock and reset first):
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `cmd_valid`  input  1: command present.
- `cmd_ready`  output  1: block idle and able to accept a command.
- `cmd_valves`  input  13: pattern for `pad_ctrl_a`.
- `cmd_select`  input  4: pattern for `pad_ctrl_s`.
- `cmd_pump`  input  1: 0 = pump A (3-valve), 1 = pump B (2-valve).
- `cmd_strokes`  input  8: number of full pump strokes, 0..255.
- `abort`  input  1: terminate current command.
- `busy`  output  1: command in progress.
- `done`  output  1: one-cycle completion pulse.
- `pad_ctrl_a`  output  13: array valve drive.
- `pad_ctrl_s`  output  4: select valve drive.
- `pad_pump_a`  output  3: pump A valve drive.
- `pad_pump_b`  output  2: pump B valve drive.

## Operation
- FSM states: IDLE, SETTLE, PUMP.
- Reset/idle values:
  - `pad_ctrl_a`=13'h1FFF, `pad_ctrl_s`=4'h0, `pad_pump_a`=3'b111, `pad_pump_b`=2'b11.
  - `busy`=0, `done`=0, state IDLE.
  - `cmd_ready`=0 while `rst` is high.
- `cmd_ready` = (state==IDLE) && !`rst`. A command is accepted on any edge where `cmd_valid` && `cmd_ready`.
- On acceptance:
  - `cmd_valves`/`cmd_select` are registered onto `pad_ctrl_a`/`pad_ctrl_s`.
  - `cmd_pump` and `cmd_strokes` are latched.
  - State goes to SETTLE and the settle counter loads 0.
- SETTLE: lasts exactly `SETTLE_CYCLES` cycles. Pumps hold idle values. Exit to PUMP, or straight to IDLE with `done` if strokes==0.
- PUMP A stroke = 6 phases, in order: 3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001. `pad_pump_b` stays 2'b11.
- PUMP B stroke = 2 phases, in order: 2'b10, 2'b01. `pad_pump_a` stays 3'b111.
- Each phase is held `PHASE_CYCLES` cycles. The phase index wraps 5→0 (A) or 1→0 (B) and increments the stroke counter. After the last phase of the last stroke: pumps return to idle, state goes to IDLE, `done` pulses.
- `pad_ctrl_a`/`pad_ctrl_s` keep the commanded pattern after `done` until the next accepted command, abort, or reset.
- `abort` (any state other than IDLE): next edge forces reset/idle values on all pad outputs and goes to IDLE. `done` is not pulsed. `abort` in IDLE only forces the pads to reset values.
- Priority: `rst` > `abort` > command acceptance. `abort` and `cmd_valid` in the same IDLE cycle: the command is dropped and `cmd_ready` is not honoured.
- `rst` mid-operation behaves like `abort`, and also clears all counters.
- Counters: settle and phase counters sized `$clog2(max+1)`. The stroke counter is 8 bit and compares with the latched stroke count, so there is no overflow at 255.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state and `rst`.
- Acceptance edge = edge 0:
  - Pad patterns are visible in cycle 1.
  - SETTLE occupies cycles 1..S (S = `SETTLE_CYCLES`).
  - Pump phases occupy cycles S+1..S+N·P·K (N = strokes, P = `PHASE_CYCLES`, K = 6 for A, 2 for B).
  - `done`=1 and `cmd_ready`=1 in cycle S+N·P·K+1.
  - When N=0, `done` is in cycle S+1.
- A back-to-back command may be accepted in the `done` cycle. Its patterns appear in the next cycle.
- `busy` = 1 exactly in cycles 1..S+N·P·K.

## Test plan
All scenarios use defaults S=4, P=2.
- Reset: hold `rst` for 3 cycles with `cmd_valid`=1 → `cmd_ready`=0; pads at 13'h1FFF/4'h0/3'b111/2'b11; no acceptance.
- Pump A, valves 13'h0A5A, select 4'b0100, strokes 2:
  - pads update in cycle 1;
  - `pad_pump_a` at 111 in cycles 1–4;
  - 101,101,100,100,… over cycles 5–28;
  - `done` in cycle 29, then `pad_pump_a`=111.
- Pump B, strokes 3 → pattern 10,10,01,01 repeated 3× in cycles 5–16; `done` in cycle 17; `pad_pump_a` stays 111 throughout.
- Strokes 0 → pumps never leave idle; `done` in cycle 5; `pad_ctrl_a` retains the command pattern afterwards.
- Abort in cycle 10 of the pump A run → cycle 11: all pads at reset values, `busy`=0, no `done` at any later cycle, `cmd_ready`=1.
- Handshake:
  - `cmd_valid` held high during `busy` → no second acceptance.
  - A second command presented in the `done` cycle → accepted, new patterns visible in the following cycle.
  - `rst` asserted mid-PUMP → same result as abort.
